// File: rtl/vga_pattern_gen.sv
// Parametrised VGA timing generator with four selectable test patterns.
// Pattern mode and base colour are sampled only at frame wrap so a frame never tears.
module vga_pattern_gen #(
  parameter int H_DISPLAY  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_DISPLAY  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int CLK_DIV    = 2,
  parameter int COLOR_W    = 1,
  parameter int BAR_SHIFT  = 6,
  parameter int CHECK_LOG2 = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           mode,
  input  logic [3*COLOR_W-1:0] color,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 video_on,
  output logic [3*COLOR_W-1:0] rgb,
  output logic [10:0]          pixel_x,
  output logic [10:0]          pixel_y,
  output logic                 p_tick,
  output logic                 frame_start
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int CW      = 3 * COLOR_W;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS    = 11'(H_DISPLAY);
  localparam logic [10:0] V_VIS    = 11'(V_DISPLAY);
  localparam logic [10:0] HS_START = 11'(H_DISPLAY + H_FRONT);
  localparam logic [10:0] HS_END   = 11'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [10:0] VS_START = 11'(V_DISPLAY + V_FRONT);
  localparam logic [10:0] VS_END   = 11'(V_DISPLAY + V_FRONT + V_SYNC);
  localparam logic [10:0] OFF_LAST = 11'(H_DISPLAY - 1);
  localparam logic [11:0] H_WIDE   = 12'(H_DISPLAY);

  typedef enum logic [1:0] {
    PAT_SOLID   = 2'd0,
    PAT_BARS    = 2'd1,
    PAT_CHECKER = 2'd2,
    PAT_SCROLL  = 2'd3
  } pattern_t;

  logic [DIV_W-1:0] div;
  logic             tick;
  logic [10:0]      h_cnt;
  logic [10:0]      v_cnt;
  logic [10:0]      offset;
  pattern_t         mode_q;
  logic [CW-1:0]    color_q;
  logic             frame_wrap;
  logic             visible;
  logic [11:0]      scroll_sum;
  logic [11:0]      scroll_x;
  logic [2:0]       idx;
  logic [CW-1:0]    pix;

  function automatic logic [CW-1:0] bar_colour(input logic [2:0] i);
    return {{COLOR_W{i[2]}}, {COLOR_W{i[1]}}, {COLOR_W{i[0]}}};
  endfunction

  assign tick        = (div == DIV_LAST);
  assign p_tick      = tick & ~reset;
  assign pixel_x     = h_cnt;
  assign pixel_y     = v_cnt;
  assign frame_wrap  = tick && (h_cnt == H_LAST) && (v_cnt == V_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     div <= '0;
    else if (tick) div <= '0;
    else           div <= div + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (tick) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? 11'd0 : v_cnt + 11'd1;
      end else begin
        h_cnt <= h_cnt + 11'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q  <= PAT_SOLID;
      color_q <= '0;
      offset  <= '0;
    end else if (frame_wrap) begin
      mode_q  <= pattern_t'(mode);
      color_q <= color;
      offset  <= (offset == OFF_LAST) ? 11'd0 : offset + 11'd1;
    end
  end

  // A single conditional subtract is an exact modulo wherever the pixel is visible,
  // since both h_cnt and offset are below H_DISPLAY there; blanking masks the rest.
  always_comb begin
    visible    = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    scroll_sum = {1'b0, h_cnt} + {1'b0, offset};
    scroll_x   = (scroll_sum >= H_WIDE) ? scroll_sum - H_WIDE : scroll_sum;
    idx        = 3'(h_cnt >> BAR_SHIFT);
    pix        = color_q;
    case (mode_q)
      PAT_SOLID:   pix = color_q;
      PAT_BARS:    pix = bar_colour(idx);
      PAT_CHECKER: pix = (h_cnt[CHECK_LOG2] ^ v_cnt[CHECK_LOG2]) ? color_q : ~color_q;
      PAT_SCROLL: begin
        idx = 3'(scroll_x >> BAR_SHIFT);
        pix = bar_colour(idx);
      end
      default:     pix = color_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      video_on    <= 1'b0;
      rgb         <= '0;
      frame_start <= 1'b0;
    end else begin
      hsync       <= !((h_cnt >= HS_START) && (h_cnt < HS_END));
      vsync       <= !((v_cnt >= VS_START) && (v_cnt < VS_END));
      video_on    <= visible;
      rgb         <= visible ? pix : '0;
      frame_start <= frame_wrap;
    end
  end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed bench for vga_pattern_gen on a shrunken 28x12 timing so many frames fit.
// Visible 20x8, hsync ticks 22..24, vsync lines 9..10, 2 clks per tick, 672 clks per frame.
module tb_vga_pattern_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  mode;
  logic [2:0]  color;
  logic        hsync;
  logic        vsync;
  logic        video_on;
  logic [2:0]  rgb;
  logic [10:0] pixel_x;
  logic [10:0] pixel_y;
  logic        p_tick;
  logic        frame_start;

  int vectors     = 0;
  int miscompares = 0;
  int n;

  vga_pattern_gen #(
    .H_DISPLAY(20), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_DISPLAY(8),  .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .CLK_DIV(2), .COLOR_W(1), .BAR_SHIFT(1), .CHECK_LOG2(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .mode(mode),
    .color(color),
    .hsync(hsync),
    .vsync(vsync),
    .video_on(video_on),
    .rgb(rgb),
    .pixel_x(pixel_x),
    .pixel_y(pixel_y),
    .p_tick(p_tick),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] m, input logic [2:0] c);
    mode  = m;
    color = c;
  endtask

  // Stops on the first clk showing counter (h,v), then samples the registered outputs for it.
  task automatic waitPos(input int h, input int v);
    int k = 0;
    while (!(pixel_x == 11'(h) && pixel_y == 11'(v)) && k < 2000) begin
      @(negedge clk);
      k++;
    end
    checkOutput($sformatf("reach_%0d_%0d", h, v), (k < 2000), 1);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic waitFrameStart();
    int k = 0;
    while (frame_start !== 1'b1 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    checkOutput("frame_start_seen", frame_start, 1);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_hsync"}, hsync, 1);
    checkOutput({tag, "_vsync"}, vsync, 1);
    checkOutput({tag, "_video_on"}, video_on, 0);
    checkOutput({tag, "_rgb"}, rgb, 0);
    checkOutput({tag, "_p_tick"}, p_tick, 0);
    checkOutput({tag, "_frame_start"}, frame_start, 0);
    checkOutput({tag, "_pixel_x"}, pixel_x, 0);
    checkOutput({tag, "_pixel_y"}, pixel_y, 0);
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(2'd0, 3'b101);
    repeat (3) @(negedge clk);
    checkResetState("rst");

    reset = 1'b0;
    #1 checkOutput("tick_0", p_tick, 0);
    @(negedge clk); checkOutput("tick_1", p_tick, 1);
    @(negedge clk); checkOutput("tick_2", p_tick, 0);
    checkOutput("x_after_tick", pixel_x, 1);
    @(negedge clk); checkOutput("tick_3", p_tick, 1);

    // Frame 0 still uses the reset-latched colour of zero.
    waitPos(3, 2);  checkOutput("f0_video_on", video_on, 1); checkOutput("f0_rgb", rgb, 3'b000);
    waitPos(21, 3); checkOutput("hs_before", hsync, 1);
    waitPos(22, 3); checkOutput("hs_first", hsync, 0);
    waitPos(24, 3); checkOutput("hs_last", hsync, 0);
    waitPos(25, 3); checkOutput("hs_after", hsync, 1);
    waitPos(0, 4);
    n = 0;
    for (int i = 0; i < 56; i++) begin
      @(negedge clk);
      if (hsync == 1'b0) n++;
    end
    checkOutput("hs_low_clks", n, 6);
    waitPos(27, 8);  checkOutput("vs_before", vsync, 1);
    waitPos(0, 9);   checkOutput("vs_first", vsync, 0);
    waitPos(27, 10); checkOutput("vs_last", vsync, 0);
    waitPos(0, 11);  checkOutput("vs_after", vsync, 1);
    waitFrameStart();
    @(negedge clk); checkOutput("fs_one_clk", frame_start, 0);

    // Frame 1: solid 101; a mid-frame switch to checkerboard must not show yet.
    waitPos(0, 0);  checkOutput("f1_rgb_00", rgb, 3'b101); checkOutput("f1_vo_00", video_on, 1);
    waitPos(19, 6); checkOutput("f1_rgb_19_6", rgb, 3'b101);
    applyStimulus(2'd2, 3'b110);
    waitPos(20, 6); checkOutput("f1_rgb_20_6", rgb, 3'b000); checkOutput("f1_vo_20_6", video_on, 0);
    waitPos(5, 7);  checkOutput("f1_no_tear", rgb, 3'b101);
    waitPos(3, 8);  checkOutput("f1_rgb_3_8", rgb, 3'b000); checkOutput("f1_vo_3_8", video_on, 0);
    waitFrameStart();

    // Frame 2: checkerboard with 4 px cells, colour 110.
    waitPos(0, 0); checkOutput("chk_0_0", rgb, 3'b001);
    waitPos(4, 0); checkOutput("chk_4_0", rgb, 3'b110);
    waitPos(0, 4); checkOutput("chk_0_4", rgb, 3'b110);
    waitPos(4, 4); checkOutput("chk_4_4", rgb, 3'b001);
    applyStimulus(2'd1, 3'b101);
    waitFrameStart();

    // Frame 3: 2 px colour bars, index wraps back to 0 at x=16.
    waitPos(0, 0);  checkOutput("bar_0", rgb, 3'b000);
    waitPos(2, 0);  checkOutput("bar_2", rgb, 3'b001);
    waitPos(15, 0); checkOutput("bar_15", rgb, 3'b111);
    waitPos(16, 0); checkOutput("bar_16", rgb, 3'b000);
    waitPos(18, 0); checkOutput("bar_18", rgb, 3'b001);
    applyStimulus(2'd3, 3'b101);
    waitFrameStart();

    // Frame 4: scrolling bars with offset 4.
    waitPos(1, 0);  checkOutput("scr4_1", rgb, 3'b010);
    waitPos(15, 0); checkOutput("scr4_15", rgb, 3'b001);
    waitPos(16, 0); checkOutput("scr4_16", rgb, 3'b000);
    waitFrameStart();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_start !== 1'b1 && n < 2000);
    checkOutput("frame_clks", n, 672);

    // Frame 6: offset 6, exercising the modulo around x+offset = 20.
    waitPos(1, 0);  checkOutput("scr6_1", rgb, 3'b011);
    waitPos(13, 0); checkOutput("scr6_13", rgb, 3'b001);
    waitPos(14, 0); checkOutput("scr6_14", rgb, 3'b000);
    waitPos(19, 2); checkOutput("scr6_19", rgb, 3'b010);
    waitPos(9, 3);  checkOutput("scr6_9", rgb, 3'b111);

    #2 reset = 1'b1;
    #1 checkResetState("async");
    @(negedge clk);
    reset = 1'b0;
    waitPos(1, 0);
    checkOutput("post_rst_vo", video_on, 1);
    checkOutput("post_rst_rgb", rgb, 3'b000);
    checkOutput("post_rst_hs", hsync, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vga_pattern_gen.md
Name: vga_pattern_gen

Overview:
Parametrised VGA timing and test-pattern generator. It replaces the fixed 640x480, switch-driven single-colour test top. The block owns its own pixel-tick divider and sync counters, and produces one of four selectable patterns at a configurable colour depth. It sits between the board clock/switches and the VGA connector, and exports pixel coordinates for downstream overlays.

Parameters:
H_DISPLAY, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_DISPLAY, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BACK, 33, vertical back porch (lines)
CLK_DIV, 2, system clocks per pixel tick (>=1)
COLOR_W, 1, bits per colour channel
BAR_SHIFT, 6, log2 of colour-bar width in pixels
CHECK_LOG2, 5, log2 of checkerboard cell size in pixels

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
mode  in  2  pattern select: 0 solid, 1 colour bars, 2 checkerboard, 3 scrolling bars
color  in  3*COLOR_W  base colour {R,G,B}, MSB channel = R
hsync  out  1  horizontal sync, active low, registered
vsync  out  1  vertical sync, active low, registered
video_on  out  1  high inside the visible area, registered
rgb  out  3*COLOR_W  pixel colour {R,G,B}, registered
pixel_x  out  11  current horizontal counter
pixel_y  out  11  current vertical counter
p_tick  out  1  one-clk pixel-enable pulse
frame_start  out  1  one-clk pulse at frame wrap

Behaviour:
- Totals: H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK; V_TOTAL is computed the same way from the V_ parameters.
- Reset (async, any time, including mid-frame):
  - div, h_cnt, v_cnt, scroll offset, latched mode and latched colour all go to 0.
  - Outputs: hsync=1, vsync=1, video_on=0, rgb=0, p_tick=0, frame_start=0.
  - After release, the first frame starts at (0,0).
- Tick divider: div counts 0..CLK_DIV-1 and wraps. p_tick is high for the single clk where div==CLK_DIV-1. With CLK_DIV=1, p_tick is constantly high.
- Counters advance only on clks with p_tick high:
  - h_cnt increments and wraps H_TOTAL-1 -> 0.
  - On that wrap, v_cnt increments and wraps V_TOTAL-1 -> 0.
  - pixel_x = h_cnt and pixel_y = v_cnt, combinational from the counters.
- Frame wrap: a p_tick clk with h_cnt==H_TOTAL-1 and v_cnt==V_TOTAL-1. On that clk edge:
  - mode and color are latched.
  - scroll offset increments by 1, wrapping at H_DISPLAY-1 -> 0.
  - frame_start is registered high for exactly the next clk.
- mode and color changes mid-frame have no visible effect until the next frame (no tearing).
- Registered outputs are computed every clk from the current counters and latched values. Latency is 1 clk after a counter change:
  - video_on = (h_cnt < H_DISPLAY) && (v_cnt < V_DISPLAY).
  - hsync = 0 when H_DISPLAY+H_FRONT <= h_cnt < H_DISPLAY+H_FRONT+H_SYNC, else 1.
  - vsync = 0 when V_DISPLAY+V_FRONT <= v_cnt < V_DISPLAY+V_FRONT+V_SYNC, else 1.
  - rgb = 0 whenever video_on would be 0 (blanking overrides every mode).
- Patterns. idx is a 3-bit bar index; a channel is all-ones when its idx bit is set: R=idx[2], G=idx[1], B=idx[0].
  - mode 0: rgb = latched colour.
  - mode 1: idx = (h_cnt >> BAR_SHIFT) mod 8. With the defaults, bars are 64 px wide and the index sequence 0..7,0,1 repeats across 640 px.
  - mode 2: if h_cnt[CHECK_LOG2] XOR v_cnt[CHECK_LOG2] is 1, rgb = latched colour, else its bitwise inverse.
  - mode 3: idx = (((h_cnt + offset) mod H_DISPLAY) >> BAR_SHIFT) mod 8. The sum is computed at 12 bits before the modulo.
- Width rules: counters are 11 bits; parameters must satisfy H_TOTAL, V_TOTAL <= 2048. Colour inversion is per bit across all 3*COLOR_W bits.

Test Plan:
- Reset release, CLK_DIV=2 -> p_tick on every 2nd clk; hsync low for exactly 96 ticks starting at h_cnt=656; a line is 800 ticks; a frame is 525 lines; vsync low on lines 490-491.
- mode=0, color=3'b101 -> rgb=101 for x<640, y<480; rgb=000 during porches and sync; video_on matches.
- mode=1 -> rgb=000 at x=0..63, 001 at x=64..127, 111 at x=448..511, 000 again at x=512.
- mode=2, color=3'b110, CHECK_LOG2=5 -> rgb=001 at (0,0); 110 at (32,0); 001 at (32,32).
- Change mode from 0 to 2 mid-frame -> current frame stays solid; the new pattern starts at (0,0) after frame_start pulses for 1 clk.
- mode=3 over 3 frames -> offset 0,1,2; at x=63 bar index is 0, 1, 1 respectively. Assert reset mid-line -> all outputs return to reset values immediately (async).
